// File: rtl/dpram_bridge_v2.sv
// Avalon-MM register bridge into a true-dual-port RAM.
// HPS side uses a 32-bit window with prefetch; arithmetic side is direct.
module dpram_bridge_v2 #(
  parameter int unsigned ID             = 1,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 11,
  parameter bit          RESET_AUTO_INC = 1'b1
) (
  input  logic                  avalon_clock,
  input  logic                  resetn,
  input  logic [4:0]            address,
  input  logic                  read,
  input  logic                  write,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  waitrequest,
  input  logic [ADDR_WIDTH-1:0] addr_arith,
  input  logic                  we_arith,
  input  logic [DATA_WIDTH-1:0] data_arith,
  output logic [DATA_WIDTH-1:0] q_arith
);

  localparam int NW    = (DATA_WIDTH + 31) / 32;
  localparam int PW    = NW * 32;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    PF_VALID,
    PF_ADDR,
    PF_LOAD
  } pf_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  pf_state_t             pf_state;
  pf_state_t             pf_next;
  logic                  pf_busy;
  logic                  pf_cap;
  logic                  pf_load;

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] pf;
  logic [PW-1:0]         pf_full;
  logic [PW-1:0]         stage;
  logic [PW-1:0]         commit_full;

  logic                  ctrl_we;
  logic                  auto_inc;
  logic                  coll;

  logic                  commit_pend;
  logic [ADDR_WIDTH-1:0] commit_addr;
  logic [DATA_WIDTH-1:0] commit_data;

  logic                  sel_data0;
  logic                  sel_ptr;
  logic                  sel_ctrl;
  logic                  sel_id;
  logic                  rd_ok;
  logic                  wr_data0;
  logic                  rd_data0;
  logic                  advance;
  logic                  ptr_wr;
  logic                  ptr_chg;
  logic                  hps_req;
  logic                  col_now;
  logic                  ram_hps_we;
  logic                  col_late;
  logic                  ram_wr;
  logic                  inval;
  logic [31:0]           rd_mux;

  assign sel_data0 = address == 5'd0;
  assign sel_ptr   = address == 5'd1;
  assign sel_ctrl  = address == 5'd2;
  assign sel_id    = address == 5'd3;

  assign waitrequest = pf_busy & ~write;
  assign rd_ok       = read & ~waitrequest;
  assign wr_data0    = write & sel_data0;
  assign rd_data0    = rd_ok & sel_data0;
  assign advance     = auto_inc & (wr_data0 | rd_data0);
  assign ptr_wr      = write & sel_ptr;
  assign ptr_chg     = ptr_wr | advance;

  // Arithmetic port wins both at request time and at the RAM write edge.
  assign hps_req    = wr_data0 & ctrl_we;
  assign col_now    = hps_req & we_arith & (addr_arith == ptr);
  assign ram_hps_we = commit_pend &
                      ~(we_arith & (addr_arith == commit_addr));
  assign col_late   = commit_pend & ~ram_hps_we;
  assign ram_wr     = we_arith | ram_hps_we;
  assign inval      = ptr_chg | ram_wr;

  assign pf_full = PW'(pf);

  always_comb begin
    commit_full       = stage;
    commit_full[31:0] = writedata;
  end

  always_ff @(posedge avalon_clock) begin
    if (we_arith)   mem[addr_arith]  <= data_arith;
    if (ram_hps_we) mem[commit_addr] <= commit_data;
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) q_arith <= '0;
    else q_arith <= we_arith ? data_arith : mem[addr_arith];
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) pf_state <= PF_ADDR;
    else pf_state <= pf_next;
  end

  always_comb begin
    pf_next = PF_VALID;
    if (inval) pf_next = PF_ADDR;
    else begin
      unique case (pf_state)
        PF_ADDR:  pf_next = PF_LOAD;
        PF_LOAD:  pf_next = PF_VALID;
        default:  pf_next = PF_VALID;
      endcase
    end
  end

  always_comb begin
    pf_busy = pf_state != PF_VALID;
    pf_cap  = pf_state == PF_ADDR;
    pf_load = pf_state == PF_LOAD;
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      rd_addr <= '0;
      pf      <= '0;
    end else begin
      if (pf_cap)  rd_addr <= ptr;
      if (pf_load) pf      <= mem[rd_addr];
    end
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) ptr <= '0;
    else if (ptr_wr) ptr <= writedata[ADDR_WIDTH-1:0];
    else if (advance) ptr <= ptr + 1'b1;
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      ctrl_we  <= 1'b0;
      auto_inc <= RESET_AUTO_INC;
      coll     <= 1'b0;
    end else begin
      if (write & sel_ctrl) begin
        ctrl_we  <= writedata[0];
        auto_inc <= writedata[1];
      end
      if (col_now | col_late) coll <= 1'b1;
      else if (write & sel_ctrl & writedata[8]) coll <= 1'b0;
    end
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) stage <= '0;
    else if (write) begin
      for (int n = 1; n < NW; n++)
        if (address == 5'(3 + n)) stage[32*n +: 32] <= writedata;
    end
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) begin
      commit_pend <= 1'b0;
      commit_addr <= '0;
      commit_data <= '0;
    end else begin
      commit_pend <= hps_req & ~col_now;
      if (hps_req) begin
        commit_addr <= ptr;
        commit_data <= commit_full[DATA_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_data0: rd_mux = pf_full[31:0];
      sel_ptr:   rd_mux = 32'(ptr);
      sel_ctrl:  rd_mux = {23'd0, coll, 6'd0, auto_inc, ctrl_we};
      sel_id:    rd_mux = ID;
      default: begin
        for (int n = 1; n < NW; n++)
          if (address == 5'(3 + n)) rd_mux = pf_full[32*n +: 32];
      end
    endcase
  end

  always_ff @(posedge avalon_clock or negedge resetn) begin
    if (!resetn) readdata <= '0;
    else if (rd_ok) readdata <= rd_mux;
  end

endmodule

// File: tb/tb_dpram_bridge_v2.sv
// Directed bench for dpram_bridge_v2: 96-bit words, 8-entry RAM.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_dpram_bridge_v2;

  localparam int DW = 96;
  localparam int AW = 3;

  logic          clk;
  logic          resetn;
  logic [4:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          waitrequest;
  logic [AW-1:0] addr_arith;
  logic          we_arith;
  logic [DW-1:0] data_arith;
  logic [DW-1:0] q_arith;

  int passed;
  int total;

  dpram_bridge_v2 #(
    .ID(32'hA5),
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .RESET_AUTO_INC(1'b1)
  ) dut (
    .avalon_clock(clk),
    .resetn(resetn),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .waitrequest(waitrequest),
    .addr_arith(addr_arith),
    .we_arith(we_arith),
    .data_arith(data_arith),
    .q_arith(q_arith)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic avw(input logic [4:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    @(negedge clk);
    write = 1'b0;
  endtask

  task automatic avr(input logic [4:0] a, output logic [31:0] d,
                     output int w);
    address = a;
    read    = 1'b1;
    w       = 0;
    #1;
    while (waitrequest && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(negedge clk);
    read = 1'b0;
    d    = readdata;
  endtask

  task automatic peek(input logic [AW-1:0] a, output logic [DW-1:0] q);
    addr_arith = a;
    repeat (2) @(negedge clk);
    q = q_arith;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    int w;
    repeat (2) @(negedge clk);
    total++;
    if (readdata !== 32'h0)
      $display("FAIL reset_readdata got %h want 0", readdata);
    else passed++;
    total++;
    if (waitrequest !== 1'b1)
      $display("FAIL reset_waitreq got %b want 1", waitrequest);
    else passed++;
    total++;
    if (q_arith !== '0)
      $display("FAIL reset_q_arith got %h want 0", q_arith);
    else passed++;
    resetn = 1'b1;
    avr(5'd2, d, w);
    total++;
    if (w !== 2) $display("FAIL reset_wait got %0d want 2", w);
    else passed++;
    total++;
    if (d !== 32'h2) $display("FAIL reset_ctrl got %h want 2", d);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h0) $display("FAIL reset_ptr got %h want 0", d);
    else passed++;
  endtask

  task automatic test_wide_write;
    logic [DW-1:0] q;
    logic [31:0] d;
    int w;
    avw(5'd2, 32'h3);
    avw(5'd1, 32'h5);
    avw(5'd4, 32'hBBBB);
    avw(5'd5, 32'hCCC);
    avw(5'd0, 32'hAAAA);
    peek(3'd5, q);
    total++;
    if (q !== 96'h00000CCC_0000BBBB_0000AAAA)
      $display("FAIL wide_ram5 got %h want cccbbbbaaaa", q);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h6) $display("FAIL wide_ptr got %h want 6", d);
    else passed++;
    avw(5'd1, 32'h5);
    avr(5'd4, d, w);
    total++;
    if (d !== 32'hBBBB) $display("FAIL rd_data1 got %h want bbbb", d);
    else passed++;
    avr(5'd5, d, w);
    total++;
    if (d !== 32'hCCC) $display("FAIL rd_data2 got %h want ccc", d);
    else passed++;
    avr(5'd0, d, w);
    total++;
    if (d !== 32'hAAAA) $display("FAIL rd_data0 got %h want aaaa", d);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h6) $display("FAIL rd_ptr got %h want 6", d);
    else passed++;
  endtask

  task automatic test_prefetch_stall;
    logic [31:0] d;
    int w;
    avw(5'd1, 32'h5);
    avr(5'd0, d, w);
    total++;
    if (w !== 2) $display("FAIL stall_cycles got %0d want 2", w);
    else passed++;
    total++;
    if (d !== 32'hAAAA) $display("FAIL stall_data got %h want aaaa", d);
    else passed++;
  endtask

  task automatic test_wrap;
    logic [DW-1:0] q;
    logic [31:0] d;
    int w;
    avw(5'd1, 32'h7);
    avw(5'd0, 32'h11);
    avw(5'd0, 32'h22);
    peek(3'd7, q);
    total++;
    if (q !== 96'h00000CCC_0000BBBB_00000011)
      $display("FAIL wrap_ram7 got %h want ccc_bbbb_11", q);
    else passed++;
    peek(3'd0, q);
    total++;
    if (q !== 96'h00000CCC_0000BBBB_00000022)
      $display("FAIL wrap_ram0 got %h want ccc_bbbb_22", q);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h1) $display("FAIL wrap_ptr got %h want 1", d);
    else passed++;
  endtask

  task automatic test_collision;
    logic [DW-1:0] q;
    logic [31:0] d;
    int w;
    avw(5'd1, 32'h2);
    addr_arith = 3'd2;
    data_arith = 96'h55;
    we_arith   = 1'b1;
    avw(5'd0, 32'h77);
    we_arith = 1'b0;
    total++;
    if (q_arith !== 96'h55)
      $display("FAIL coll_through got %h want 55", q_arith);
    else passed++;
    peek(3'd2, q);
    total++;
    if (q !== 96'h55) $display("FAIL coll_ram2 got %h want 55", q);
    else passed++;
    avr(5'd2, d, w);
    total++;
    if (d !== 32'h103) $display("FAIL coll_ctrl got %h want 103", d);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h3) $display("FAIL coll_ptr got %h want 3", d);
    else passed++;
    avw(5'd2, 32'h103);
    avr(5'd2, d, w);
    total++;
    if (d !== 32'h3) $display("FAIL coll_clear got %h want 3", d);
    else passed++;
  endtask

  task automatic test_no_we;
    logic [DW-1:0] q;
    logic [31:0] d;
    int w;
    avw(5'd2, 32'h0);
    avw(5'd1, 32'h5);
    avw(5'd0, 32'hDEAD);
    peek(3'd5, q);
    total++;
    if (q !== 96'h00000CCC_0000BBBB_0000AAAA)
      $display("FAIL nowe_ram5 got %h want unchanged", q);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h5) $display("FAIL nowe_ptr got %h want 5", d);
    else passed++;
    avr(5'd20, d, w);
    total++;
    if (d !== 32'h0) $display("FAIL unmapped20 got %h want 0", d);
    else passed++;
    avr(5'd6, d, w);
    total++;
    if (d !== 32'h0) $display("FAIL unmapped6 got %h want 0", d);
    else passed++;
    avr(5'd3, d, w);
    total++;
    if (d !== 32'hA5) $display("FAIL id got %h want a5", d);
    else passed++;
  endtask

  task automatic test_reset_mid_read;
    logic [31:0] d;
    int w;
    avw(5'd1, 32'h4);
    address = 5'd2;
    read    = 1'b1;
    #1;
    total++;
    if (waitrequest !== 1'b1)
      $display("FAIL mid_pre_wait got %b want 1", waitrequest);
    else passed++;
    resetn = 1'b0;
    #1;
    total++;
    if (readdata !== 32'h0)
      $display("FAIL mid_readdata got %h want 0", readdata);
    else passed++;
    total++;
    if (q_arith !== '0)
      $display("FAIL mid_q_arith got %h want 0", q_arith);
    else passed++;
    @(negedge clk);
    resetn = 1'b1;
    avr(5'd2, d, w);
    total++;
    if (w !== 2) $display("FAIL mid_wait got %0d want 2", w);
    else passed++;
    total++;
    if (d !== 32'h2) $display("FAIL mid_ctrl got %h want 2", d);
    else passed++;
    avr(5'd1, d, w);
    total++;
    if (d !== 32'h0) $display("FAIL mid_ptr got %h want 0", d);
    else passed++;
  endtask

  initial begin
    passed     = 0;
    total      = 0;
    resetn     = 1'b0;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    addr_arith = '0;
    we_arith   = 1'b0;
    data_arith = '0;
    @(negedge clk);
    test_reset;
    test_wide_write;
    test_prefetch_stall;
    test_wrap;
    test_collision;
    test_no_we;
    addr_arith = 3'd5;
    test_reset_mid_read;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dpram_bridge_v2.md
# dpram_bridge_v2

Parametrised Avalon-MM register bridge into a single-clock, true-dual-port RAM: the HPS side moves DATA_WIDTH-bit words through a 32-bit slave window, and the arithmetic side gets a direct synchronous port. Successor to the fixed 512-bit staging bridge:
- width- and depth-generic;
- optional auto-increment;
- prefetch register with waitrequest, so no stale read data;
- defined collision priority with a sticky collision flag.

Sits between the HPS lightweight bridge and an arithmetic test core.

## Interface
- ID, 1: constant returned at register 3.
- DATA_WIDTH, 32: RAM word width, 1..512. NWORDS = ceil(DATA_WIDTH/32).
- ADDR_WIDTH, 11: RAM address width, 1..16. Depth = 2**ADDR_WIDTH.
- RESET_AUTO_INC, 1: reset value of CTRL.auto_inc.
- avalon_clock  in  1  sole clock for both ports.
- resetn  in  1  asynchronous, active-low reset.
- address  in  5  slave register index.
- read, write  in  1 each  Avalon strobes.
- writedata  in  32  slave write data.
- readdata  out  32  registered read data.
- waitrequest  out  1  stalls reads while the prefetch is invalid.
- addr_arith  in  ADDR_WIDTH  arithmetic-port address.
- we_arith  in  1  arithmetic-port write enable.
- data_arith  in  DATA_WIDTH  arithmetic-port write data.
- q_arith  out  DATA_WIDTH  arithmetic-port read data.

## Operation
Register map (32-bit words):
- 0 DATA0: word bits [31:0].
  - Write: commits {stage, writedata} to RAM[ptr] if CTRL.we.
  - Read: returns pf[31:0].
- 1 PTR: HPS address pointer ptr; readback is zero-extended.
- 2 CTRL: bit0 we, bit1 auto_inc, bit8 collision (sticky). Writing 1 to bit8 clears it; writing 0 leaves it unchanged.
- 3 ID.
- 4..4+NWORDS-2 DATAn, n=1..NWORDS-1: word bits [32n+31:32n].
  - Write: stages into the stage register only.
  - Read: returns pf[32n+31:32n].
- All other addresses: writes ignored, reads return 0.

Data handling:
- Bits above DATA_WIDTH in the top word read as 0 and are discarded on write.
- Commit = stage bits above bit 31 concatenated with writedata[31:0]. The stage register persists after a commit.

Pointer advance:
- Each DATA0 write advances ptr by 1 if auto_inc, regardless of CTRL.we.
- Each accepted DATA0 read (waitrequest low) advances ptr by 1 if auto_inc. Upper DATAn words of a word must be read before its DATA0.
- ptr wraps from 2**ADDR_WIDTH-1 to 0 silently.

Prefetch:
- pf holds RAM[ptr].
- Any ptr change, or any RAM write by either port, invalidates pf and reloads it from RAM[ptr]. The reload restarts if another invalidating event occurs during it.

Collision:
- A same-cycle write by both ports to the same address gives the arithmetic port priority.
- The HPS write is dropped, collision is set, and ptr still advances.
- Same-address read/write across ports: the read returns old data.

Writes never stall.

## Timing
- RAM read latency is 1 cycle on both ports.
- Arithmetic port: q_arith is RAM[addr_arith] registered at the next edge. On we_arith, q_arith = data_arith (write-through).
- Prefetch: an invalidating event at edge t gives pf valid after edge t+2. waitrequest is high for any read presented in cycles t+1..t+2 and low otherwise.
- Read accepted at edge t (read=1, waitrequest=0): readdata is valid after edge t. The Avalon component uses readLatency 1.
- Back-to-back DATA0 reads with auto_inc: one word per 3 cycles.
- DATA0 write at edge t with CTRL.we=1: RAM written at edge t+1. A subsequent read of the same address returns the new data.

Reset values (async, on resetn low):
- readdata 0, waitrequest 1, ptr 0, stage 0.
- CTRL.we 0, CTRL.auto_inc = RESET_AUTO_INC, collision 0.
- q_arith 0, pf invalid.
- RAM contents are not reset.

After reset release:
- waitrequest drops after 2 cycles, with pf = RAM[0].
- Reset asserted mid-commit aborts the commit. RAM contents at ptr are then undefined.

## Test plan
- DATA_WIDTH=96, auto_inc=1:
  - Stimulus: write CTRL=3, PTR=5, DATA1=0xBBBB, DATA2=0xCCC, DATA0=0xAAAA.
  - Required: RAM[5]=0x00000CCC_0000BBBB_0000AAAA, ptr=6.
  - Then write PTR=5, read DATA1, DATA2, DATA0 → 0xBBBB, 0xCCC, 0xAAAA, then ptr=6.
- Prefetch stall:
  - Stimulus: write PTR, then read DATA0 in the next cycle.
  - Required: waitrequest high for exactly 2 cycles, then correct data; never stale.
- Wrap, ADDR_WIDTH=3:
  - Stimulus: PTR=7, write DATA0 twice.
  - Required: RAM[7] then RAM[0] written, PTR reads 1.
- Collision:
  - Stimulus: HPS DATA0 write and we_arith in the same cycle, both to address 2, data_arith=0x55.
  - Required: RAM[2]=0x55, CTRL reads 0x103.
  - Then write CTRL bit8=1 → collision clears.
- CTRL.we=0, auto_inc=0:
  - Stimulus: write DATA0.
  - Required: RAM unchanged, ptr unchanged.
  - Reads of unmapped address 20 return 0; ID register returns parameter ID.
- Reset mid-read:
  - Stimulus: assert resetn low while waitrequest is high.
  - Required: all registers at reset values immediately; waitrequest low 2 cycles after release.
